// File: rtl/mac_job_sequencer_pkg.sv
// Shared types and widths for the MAC job sequencer.
// Imported by the datapath and the sequencer top.
package mac_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int ACC_W  = 41;
  localparam int OP_W   = 16;
  localparam int PROD_W = 32;

endpackage

// File: rtl/mac_job_sequencer_alu.sv
// Signed 16x16 multiply-accumulate datapath.
// Purely combinational; the caller owns the accumulator.
module alu
  import mac_seq_pkg::*;
(
  input  logic [OP_W-1:0]  x,
  input  logic [OP_W-1:0]  b,
  input  logic             zero,
  input  logic [ACC_W-1:0] sum_in,
  output logic [ACC_W-1:0] addend,
  output logic [ACC_W-1:0] sum_out
);

  logic signed [PROD_W-1:0] prod;

  always_comb begin
    prod = $signed(x) * $signed(b);
    addend = zero ? '0
                  : {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    sum_out = sum_in + addend;
  end

endmodule

// File: rtl/mac_job_sequencer.sv
// Job-level sequencer around the MAC datapath:
// length-bounded operand stream in, one sum out.
module mac_job_sequencer
  import mac_seq_pkg::*;
#(
  parameter int LEN_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [LEN_W-1:0] start_len,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [OP_W-1:0]  op_x,
  input  logic [OP_W-1:0]  op_b,
  input  logic             op_zero,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ACC_W-1:0] res_sum,
  output logic             res_ovf,
  output logic             busy
);

  state_t           state_q;
  state_t           state_d;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] addend;
  logic [ACC_W-1:0] sum_out;
  logic [LEN_W-1:0] count_q;
  logic [LEN_W-1:0] len_q;
  logic             ovf_q;
  logic             last_op;
  logic             wrap;

  alu u_alu (
    .x       (op_x),
    .b       (op_b),
    .zero    (op_zero),
    .sum_in  (acc_q),
    .addend  (addend),
    .sum_out (sum_out)
  );

  assign start_ready = (state_q == IDLE);
  assign op_ready    = (state_q == RUN);
  assign res_valid   = (state_q == DONE);
  assign busy        = (state_q != IDLE);
  assign res_sum     = acc_q;
  assign res_ovf     = ovf_q;

  assign last_op = (count_q == len_q - LEN_W'(1));
  // Same-sign operands whose sum flips sign wrapped.
  assign wrap = (acc_q[ACC_W-1] == addend[ACC_W-1])
             && (sum_out[ACC_W-1] != acc_q[ACC_W-1]);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (start_valid)
          state_d = (start_len == '0) ? DONE : RUN;
      RUN:
        if (op_valid && last_op)
          state_d = DONE;
      DONE:
        if (res_ready)
          state_d = IDLE;
      default:
        state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      count_q <= '0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_ready && start_valid) begin
        len_q   <= start_len;
        acc_q   <= '0;
        count_q <= '0;
        ovf_q   <= 1'b0;
      end
      if (op_ready && op_valid) begin
        acc_q   <= sum_out;
        ovf_q   <= ovf_q | wrap;
        count_q <= count_q + LEN_W'(1);
      end
    end
  end

  default clocking cb @(posedge clk);
  endclocking

  a_count_le_len: assert property (
    disable iff (!rst_n) count_q <= len_q);

  a_no_op_and_res: assert property (
    disable iff (!rst_n) !(op_ready && res_valid));

  a_res_stable: assert property (
    disable iff (!rst_n)
    res_valid && !res_ready && rst_n |=> $stable(res_sum));

  a_one_hot_hs: assert property (
    disable iff (!rst_n)
    $onehot({start_ready, op_ready, res_valid}));

endmodule

// File: tb/tb_mac_job_sequencer.sv
// Directed self-checking bench for mac_job_sequencer.
// Inputs change 1ns after posedge; outputs sampled there too.
module tb_mac_job_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_valid;
  logic        start_ready;
  logic [11:0] start_len;
  logic        op_valid;
  logic        op_ready;
  logic [15:0] op_x;
  logic [15:0] op_b;
  logic        op_zero;
  logic        res_valid;
  logic        res_ready;
  logic [40:0] res_sum;
  logic        res_ovf;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mac_job_sequencer #(.LEN_W(12)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .start_len   (start_len),
    .op_valid    (op_valid),
    .op_ready    (op_ready),
    .op_x        (op_x),
    .op_b        (op_b),
    .op_zero     (op_zero),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_sum     (res_sum),
    .res_ovf     (res_ovf),
    .busy        (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int len);
    start_valid = 1'b1;
    start_len   = 12'(len);
    tick();
    start_valid = 1'b0;
  endtask

  task automatic send(input int x, input int b, input bit z);
    op_valid = 1'b1;
    op_x     = 16'(x);
    op_b     = 16'(b);
    op_zero  = z;
    tick();
    op_valid = 1'b0;
    op_zero  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    n_checks++;
    if (res_valid !== 1'b0 || op_ready !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outs got rv=%b or=%b busy=%b exp 0 0 0",
               res_valid, op_ready, busy);
    end
    n_checks++;
    if (res_sum !== 41'd0 || res_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_sum got %0d ovf=%b exp 0 0",
               $signed(res_sum), res_ovf);
    end
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (start_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_start_ready got %b exp 1", start_ready);
    end
  endtask

  task automatic test_basic();
    res_ready = 1'b1;
    start_job(3);
    n_checks++;
    if (op_ready !== 1'b1 || busy !== 1'b1 || start_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_run got or=%b busy=%b sr=%b exp 1 1 0",
               op_ready, busy, start_ready);
    end
    send(2, 3, 0);
    send(-4, 5, 0);
    n_checks++;
    if (res_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_early_res got %b exp 0", res_valid);
    end
    send(7, -1, 0);
    n_checks++;
    if (res_valid !== 1'b1 || op_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_res_valid got rv=%b or=%b exp 1 0",
               res_valid, op_ready);
    end
    n_checks++;
    if (res_sum !== 41'(-21) || res_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_sum got %0d ovf=%b exp -21 0",
               $signed(res_sum), res_ovf);
    end
    tick();
    n_checks++;
    if (start_ready !== 1'b1 || res_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_idle got sr=%b rv=%b exp 1 0",
               start_ready, res_valid);
    end
  endtask

  task automatic test_mask_bubble();
    res_ready = 1'b1;
    start_job(2);
    send(100, 100, 1);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (op_ready !== 1'b1 || res_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL bubble_%0d got or=%b rv=%b exp 1 0",
                 i, op_ready, res_valid);
      end
      tick();
    end
    send(-3, -3, 0);
    n_checks++;
    if (res_valid !== 1'b1 || res_sum !== 41'd9) begin
      n_fail++;
      $display("FAIL mask_sum got rv=%b sum=%0d exp 1 9",
               res_valid, $signed(res_sum));
    end
    tick();
  endtask

  task automatic test_zero_len();
    res_ready = 1'b0;
    start_job(0);
    n_checks++;
    if (res_valid !== 1'b1 || op_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL zlen_res got rv=%b or=%b exp 1 0",
               res_valid, op_ready);
    end
    n_checks++;
    if (res_sum !== 41'd0 || res_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL zlen_sum got %0d ovf=%b exp 0 0",
               $signed(res_sum), res_ovf);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (res_valid !== 1'b1 || res_sum !== 41'd0 || op_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL zlen_hold_%0d got rv=%b sum=%0d or=%b exp 1 0 0",
                 i, res_valid, $signed(res_sum), op_ready);
      end
    end
    res_ready = 1'b1;
    tick();
    n_checks++;
    if (start_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL zlen_idle got %b exp 1", start_ready);
    end
  endtask

  task automatic test_overflow();
    res_ready = 1'b1;
    start_job(4095);
    for (int i = 0; i < 4095; i++)
      send(-32768, -32768, 0);
    n_checks++;
    if (res_valid !== 1'b1 || res_ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_flag got rv=%b ovf=%b exp 1 1",
               res_valid, res_ovf);
    end
    n_checks++;
    if (res_sum !== 41'(-64'sd1073741824)) begin
      n_fail++;
      $display("FAIL ovf_sum got %0d exp -1073741824",
               $signed(res_sum));
    end
    tick();
  endtask

  task automatic test_reset_mid();
    res_ready = 1'b1;
    start_job(5);
    send(1, 1, 0);
    send(2, 2, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (res_valid !== 1'b0 || start_ready !== 1'b1 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL rstmid_%0d got rv=%b sr=%b busy=%b exp 0 1 0",
                 i, res_valid, start_ready, busy);
      end
      tick();
    end
    start_job(1);
    send(6, 7, 0);
    n_checks++;
    if (res_valid !== 1'b1 || res_sum !== 41'd42 || res_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_next got rv=%b sum=%0d ovf=%b exp 1 42 0",
               res_valid, $signed(res_sum), res_ovf);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    res_ready   = 1'b0;
    start_valid = 1'b1;
    start_len   = 12'd1;
    tick();
    start_len = 12'd2;
    send(3, 4, 0);
    n_checks++;
    if (res_sum !== 41'd12 || start_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_first got sum=%0d sr=%b exp 12 0",
               $signed(res_sum), start_ready);
    end
    tick();
    n_checks++;
    if (res_valid !== 1'b1 || start_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_hold got rv=%b sr=%b exp 1 0",
               res_valid, start_ready);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    n_checks++;
    if (start_ready !== 1'b1 || op_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_idle got sr=%b or=%b exp 1 0",
               start_ready, op_ready);
    end
    tick();
    start_valid = 1'b0;
    n_checks++;
    if (op_ready !== 1'b1 || start_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_second_run got or=%b sr=%b exp 1 0",
               op_ready, start_ready);
    end
    send(-5, 2, 0);
    send(1, 1, 0);
    n_checks++;
    if (res_valid !== 1'b1 || res_sum !== 41'(-9)) begin
      n_fail++;
      $display("FAIL b2b_second_sum got rv=%b sum=%0d exp 1 -9",
               res_valid, $signed(res_sum));
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    start_valid = 1'b0;
    start_len   = '0;
    op_valid    = 1'b0;
    op_x        = '0;
    op_b        = '0;
    op_zero     = 1'b0;
    res_ready   = 1'b0;
    test_reset();
    test_basic();
    test_mask_bubble();
    test_zero_len();
    test_overflow();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
